empaquetador_simbolos_2a8: RTL and testbench

- Downstream consumer of the 2-bit memory mux output. Collects four consecutive 2-bit symbols into one byte and buffers completed bytes in a small synchronous FIFO.
- Presents bytes to the next stage with a valid/ready handshake.
- Flags any symbol lost because the mux cannot be back-pressured, and counts delivered bytes.

---
 rtl/empaquetador_simbolos_2a8_pkg.sv | 10 +
 rtl/empaquetador_simbolos_2a8_fifo.sv | 42 ++++
 rtl/empaquetador_simbolos_2a8.sv | 83 ++++++++
 tb/tb_empaquetador_simbolos_2a8.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/empaquetador_simbolos_2a8_pkg.sv
// Shared widths and defaults for the 2-bit symbol to byte packer and its FIFO.
package empaquetador_simbolos_2a8_pkg;
    localparam int SYM_W         = 2;
    localparam int SYMS_PER_WORD = 4;
    localparam int WORD_W        = SYM_W * SYMS_PER_WORD;
    localparam int FIFO_DEPTH    = 2;
    localparam int CNT_W         = 8;
    localparam int IDX_W         = (SYMS_PER_WORD > 1) ? $clog2(SYMS_PER_WORD) : 1;
    localparam int PTR_W         = $clog2(FIFO_DEPTH) + 1;
endpackage

// File: rtl/empaquetador_simbolos_2a8_fifo.sv
// Synchronous FIFO, power-of-two depth, pointers one bit wider than the address.
module fifo_sincrono #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // Same address with differing wrap bit means the write side has lapped the read side.
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign dout  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push && !full)
            mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/empaquetador_simbolos_2a8.sv
// Packs four LSB-first 2-bit symbols into a byte, buffers bytes, flags dropped symbols.
module empaquetador_simbolos_2a8
    import empaquetador_simbolos_2a8_pkg::*;
#(
    parameter int SYM_W         = empaquetador_simbolos_2a8_pkg::SYM_W,
    parameter int SYMS_PER_WORD = empaquetador_simbolos_2a8_pkg::SYMS_PER_WORD,
    parameter int FIFO_DEPTH    = empaquetador_simbolos_2a8_pkg::FIFO_DEPTH,
    parameter int CNT_W         = empaquetador_simbolos_2a8_pkg::CNT_W
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           valid_in,
    input  logic [SYM_W-1:0]               data_in,
    output logic                           ready_in,
    output logic [SYM_W*SYMS_PER_WORD-1:0] data_out,
    output logic                           valid_out,
    input  logic                           ready_out,
    output logic                           overflow,
    output logic [CNT_W-1:0]               word_count
);
    localparam int WW  = SYM_W * SYMS_PER_WORD;
    localparam int IW  = (SYMS_PER_WORD > 1) ? $clog2(SYMS_PER_WORD) : 1;

    logic [IW-1:0] idx;
    logic [WW-1:0] assembly;
    logic [WW-1:0] word_next;
    logic          accept;
    logic          last_sym;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;

    assign ready_in  = !full;
    assign valid_out = !empty;
    assign accept    = valid_in && ready_in;
    assign last_sym  = (idx == IW'(SYMS_PER_WORD - 1));
    assign push      = accept && last_sym;
    assign pop       = valid_out && ready_out;

    // Higher slots are still zero, so overlaying the new symbol yields the full word on the last one.
    always_comb begin
        word_next = assembly;
        word_next[SYM_W*idx +: SYM_W] = data_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx        <= '0;
            assembly   <= '0;
            overflow   <= 1'b0;
            word_count <= '0;
        end else begin
            if (accept) begin
                if (last_sym) begin
                    idx      <= '0;
                    assembly <= '0;
                end else begin
                    idx      <= idx + 1'b1;
                    assembly <= word_next;
                end
            end
            if (valid_in && !ready_in)
                overflow <= 1'b1;
            if (pop)
                word_count <= word_count + 1'b1;
        end
    end

    fifo_sincrono #(
        .WIDTH (WW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (word_next),
        .dout  (data_out),
        .full  (full),
        .empty (empty)
    );
endmodule

// File: tb/tb_empaquetador_simbolos_2a8.sv
// Scoreboard bench: stimulus predicts words from a symbol-list model, a negedge monitor checks pops.
module tb_empaquetador_simbolos_2a8;
    localparam int DEPTH = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       valid_in;
    logic [1:0] data_in;
    logic       ready_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       ready_out;
    logic       overflow;
    logic [7:0] word_count;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    logic [7:0] exp_q[$];
    logic [1:0] sym_q[$];
    int         occ;
    logic       ovf_m;
    logic [7:0] count_m;

    empaquetador_simbolos_2a8 dut (
        .clk        (clk),
        .reset      (reset),
        .valid_in   (valid_in),
        .data_in    (data_in),
        .ready_in   (ready_in),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .ready_out  (ready_out),
        .overflow   (overflow),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            check("valid_out", valid_out, exp_q.size() != 0);
            if (exp_q.size() == 0)
                check("data_out_empty", data_out, 0);
            check("word_count", word_count, count_m);
            if (valid_out && ready_out) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pop", 1, 0);
                end else begin
                    check("data_out", data_out, exp_q.pop_front());
                end
                count_m = count_m + 8'd1;
            end
        end
    end

    task automatic clear_model();
        exp_q.delete();
        sym_q.delete();
        occ     = 0;
        ovf_m   = 1'b0;
        count_m = '0;
    endtask

    // Called at posedge+1; the model decides acceptance from its own occupancy count.
    task automatic cycle(input logic v, input logic [1:0] d, input logic r);
        logic       acc;
        logic       pp;
        logic       ps;
        logic [7:0] w;
        valid_in  = v;
        data_in   = d;
        ready_out = r;
        check("ready_in", ready_in, occ < DEPTH);
        acc = v && (occ < DEPTH);
        pp  = r && (occ > 0);
        ps  = 1'b0;
        @(posedge clk);
        #1;
        if (v && !acc)
            ovf_m = 1'b1;
        if (acc) begin
            sym_q.push_back(d);
            if (sym_q.size() == 4) begin
                w = '0;
                for (int i = 0; i < 4; i++)
                    w = w | (8'(sym_q[i]) << (2 * i));
                exp_q.push_back(w);
                sym_q.delete();
                ps = 1'b1;
            end
        end
        occ = occ + int'(ps) - int'(pp);
        check("overflow", overflow, ovf_m);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        valid_in  = 1'b0;
        data_in   = '0;
        ready_out = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_model();
        check("rst_valid_out", valid_out, 0);
        check("rst_data_out", data_out, 0);
        check("rst_ready_in", ready_in, 1);
        check("rst_word_count", word_count, 0);
        check("rst_overflow", overflow, 0);
    endtask

    initial begin
        logic [1:0] pat1 [4];
        pat1 = '{2'b01, 2'b10, 2'b11, 2'b00};
        clear_model();
        reset = 1'b1; valid_in = 1'b0; data_in = '0; ready_out = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // 1: single word 0x39
        for (int i = 0; i < 4; i++) cycle(1'b1, pat1[i], 1'b1);
        check("t1_data", data_out, 8'h39);
        cycle(1'b0, 2'b00, 1'b1);
        cycle(1'b0, 2'b00, 1'b1);
        check("t1_count", word_count, 1);

        // 2: back-pressure, drops, then drain
        for (int i = 0; i < 12; i++) cycle(1'b1, 2'b11, 1'b0);
        check("t2_ready_in", ready_in, 0);
        check("t2_overflow", overflow, 1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 2'b00, 1'b1);
        check("t2_count", word_count, 3);
        check("t2_overflow_sticky", overflow, 1);

        // 3: continuous stream 0xE4
        do_reset();
        for (int i = 0; i < 32; i++) cycle(1'b1, 2'(i % 4), 1'b1);
        cycle(1'b0, 2'b00, 1'b1);
        check("t3_count", word_count, 8);

        // 4: reset with a partial word and a buffered word
        for (int i = 0; i < 6; i++) cycle(1'b1, 2'b01, 1'b0);
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, 2'b11, 1'b0);
        check("t4_data", data_out, 8'hFF);
        cycle(1'b0, 2'b00, 1'b1);

        // 5: counter wrap after 256 pops
        do_reset();
        for (int i = 0; i < 1024; i++) cycle(1'b1, 2'($urandom_range(0, 3)), 1'b1);
        cycle(1'b0, 2'b00, 1'b1);
        check("t5_wrap", word_count, 0);

        // 6: gapped valid_in with 0xAA
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'(i % 2 == 0), 2'b10, 1'b1);
        cycle(1'b0, 2'b00, 1'b1);
        check("t6_count", word_count, 1);

        // Random traffic
        do_reset();
        for (int i = 0; i < 800; i++)
            cycle(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 2) != 0));
        for (int i = 0; i < 6; i++) cycle(1'b0, 2'b00, 1'b1);
        check("drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
